time_config_ctrl: RTL and testbench
===================================

TIME_CONFIG_CTRL -- requirements
Module: time_config_ctrl

Interface
REQ-001 The block SHALL have these ports, each line giving name, direction, width and meaning:
- clock  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high.
- btn_mode  input  1  one-cycle pulse, debounced upstream; advances mode.
- btn_up  input  1  one-cycle pulse; increments selected field.
- btn_down  input  1  one-cycle pulse; decrements selected field.
- btn_left  input  1  one-cycle pulse; moves cursor left.
- btn_right  input  1  one-cycle pulse; moves cursor right.
- fmt_toggle  input  1  one-cycle pulse; toggles 12/24 h display.
- rtc_time_bcd  input  24  {HH,MM,SS} BCD from the RTC.
- rtc_date_bcd  input  24  {DD,MM,YY} BCD from the RTC.
- rtc_valid  input  1  RTC buses are valid this cycle.
- wr_ack  input  1  RTC accepted a write.
- time_bcd  output  24  displayed {HH,MM,SS}; HH is converted when 12 h format is active.
- date_bcd  output  24  displayed {DD,MM,YY}.
- timer_bcd  output  24  configured timer {HH,MM,SS}.
- AM_PM  output  1  1 = PM.
- formato_hora  output  1  1 = 12 h format.
- config_mode  output  3  current state code.
- cursor_location  output  2  selected field: 0 = left pair, 2 = right pair.
- wr_req  output  1  write request to the RTC.
- wr_time_bcd  output  24  time payload for the RTC write.
- wr_date_bcd  output  24  date payload for the RTC write.

Function
REQ-002 The FSM SHALL have these states and config_mode codes: NORMAL=000, CFG_TIME=001, CFG_DATE=010, CFG_TIMER=011, WRITE=100.
REQ-003 On btn_mode the FSM SHALL advance one state per cycle: NORMAL->CFG_TIME->CFG_DATE->CFG_TIMER->WRITE; btn_mode in WRITE SHALL be ignored.
REQ-004 In WRITE, wr_req SHALL be asserted the cycle after entry and held with stable payload until wr_ack is sampled high; the FSM SHALL then return to NORMAL and deassert wr_req in the same cycle.
REQ-005 In NORMAL, the time and date registers SHALL load rtc_time_bcd and rtc_date_bcd on every cycle rtc_valid=1; in all other states, RTC inputs SHALL be ignored.
REQ-006 cursor_location SHALL take only the values 0..2: btn_right SHALL increment it with 2->0 wrap, and btn_left SHALL decrement it with 0->2 wrap.
REQ-007 cursor_location SHALL clear to 0 on every state change.
REQ-008 In a CFG state, btn_up/btn_down SHALL adjust the selected BCD pair by 1 with wrap, effective the next cycle.
REQ-009 Pair ranges SHALL be: hours 00-23, minutes and seconds 00-59, day 01-31, month 01-12, year 00-99, timer hours 00-23.
REQ-010 If btn_up and btn_down arrive in the same cycle, the field SHALL be unchanged.
REQ-011 If btn_mode arrives together with any adjust or cursor pulse, only btn_mode SHALL take effect.
REQ-012 Hours SHALL be stored in 24 h form; AM_PM SHALL equal (HH>=12).
REQ-013 With formato_hora=1, displayed HH SHALL map 00->12, 13..23->01..11, and leave 01..12 unchanged; the map SHALL be combinational on the registered value.
REQ-014 fmt_toggle SHALL toggle formato_hora in any state.
REQ-015 The write payload SHALL always carry 24 h form.
REQ-016 All outputs except the displayed-HH conversion SHALL be registered.

Reset
REQ-017 Reset SHALL force: state NORMAL; cursor 0; time 00:00:00; date 01/01/00; timer 00:00:00; formato_hora 0; wr_req 0.
REQ-018 Reset asserted during WRITE SHALL drop wr_req immediately (asynchronously); the pending write SHALL be abandoned.

Configuration
REQ-019 With TIMER_CFG_EN defined, behaviour SHALL be as above.
REQ-020 Without TIMER_CFG_EN:
- the CFG_TIMER state SHALL be absent;
- CFG_DATE+btn_mode SHALL go directly to WRITE;
- timer_bcd SHALL be constant 0;
- code 011 SHALL never appear on config_mode.

Structure
REQ-021 A shared package SHALL hold the state codes, the per-field min/max BCD limits, and the cursor width.
REQ-022 One sub-module, bcd_pair_adj, SHALL implement combinational BCD +/-1 with min/max wrap; it SHALL be instantiated once, with the field selected by a multiplexer.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset, then NORMAL with rtc_valid=1 and rtc_time_bcd=0x235959 -> time_bcd=0x235959 next cycle; AM_PM=1.
- CFG_TIME, cursor 0, HH=23, btn_up -> HH=00; then btn_down -> HH=23.
- CFG_DATE, cursor 1, month=12, btn_up -> 01; cursor 0, day=01, btn_down -> 31.
- formato_hora=1, HH=00 -> time_bcd[23:16]=0x12, AM_PM=0; HH=13 -> 0x01, AM_PM=1.
- Enter WRITE, hold wr_ack=0 for 5 cycles -> wr_req stays 1 with stable payload; wr_ack=1 -> NORMAL next cycle, wr_req=0.
- btn_mode+btn_up in the same cycle in CFG_TIME -> state becomes CFG_DATE, time unchanged, cursor 0; reset during WRITE -> wr_req=0 immediately.

Source files
------------

// File: rtl/time_config_ctrl_pkg.sv
// Shared definitions for the time/date configuration controller: state codes,
// BCD field limits and cursor width.
package time_config_ctrl_pkg;

    localparam int CUR_W = 2;

    typedef enum logic [2:0] {
        NORMAL    = 3'b000,
        CFG_TIME  = 3'b001,
        CFG_DATE  = 3'b010,
        CFG_TIMER = 3'b011,
        WRITE     = 3'b100
    } state_e;

    localparam logic [7:0] HOUR_MIN   = 8'h00;
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MIN = 8'h00;
    localparam logic [7:0] MINSEC_MAX = 8'h59;
    localparam logic [7:0] DAY_MIN    = 8'h01;
    localparam logic [7:0] DAY_MAX    = 8'h31;
    localparam logic [7:0] MONTH_MIN  = 8'h01;
    localparam logic [7:0] MONTH_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MIN   = 8'h00;
    localparam logic [7:0] YEAR_MAX   = 8'h99;

    localparam logic [23:0] TIME_RST  = 24'h000000;
    localparam logic [23:0] DATE_RST  = 24'h010100;
    localparam logic [23:0] TIMER_RST = 24'h000000;

    // Returns {min, max} of the pair the cursor points at in the given state.
    function automatic logic [15:0] field_limits(input state_e st, input logic [CUR_W-1:0] cur);
        logic [15:0] lim;
        lim = {HOUR_MIN, HOUR_MAX};
        if (st == CFG_DATE) begin
            case (cur)
                2'd0:    lim = {DAY_MIN, DAY_MAX};
                2'd1:    lim = {MONTH_MIN, MONTH_MAX};
                default: lim = {YEAR_MIN, YEAR_MAX};
            endcase
        end else if (cur != '0) begin
            lim = {MINSEC_MIN, MINSEC_MAX};
        end
        return lim;
    endfunction

endpackage

// File: rtl/time_config_ctrl_bcd_pair_adj.sv
// Combinational +/-1 on a two-digit BCD value, wrapping between min and max.
// Simultaneous inc and dec leave the value unchanged.
module bcd_pair_adj (
    input  logic [7:0] val,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result
);

    always_comb begin
        result = val;
        if (inc && !dec) begin
            if (val >= max_val) begin
                result = min_val;
            end else if (val[3:0] == 4'd9) begin
                result = {val[7:4] + 4'd1, 4'd0};
            end else begin
                result = {val[7:4], val[3:0] + 4'd1};
            end
        end else if (dec && !inc) begin
            if (val <= min_val) begin
                result = max_val;
            end else if (val[3:0] == 4'd0) begin
                result = {val[7:4] - 4'd1, 4'd9};
            end else begin
                result = {val[7:4], val[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/time_config_ctrl.sv
// Clock/date configuration controller: mirrors the RTC in NORMAL, lets the user
// edit time/date/timer pairs, then writes back. Optional timer editing: TIMER_CFG_EN.
module time_config_ctrl
    import time_config_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        fmt_toggle,
    input  logic [23:0] rtc_time_bcd,
    input  logic [23:0] rtc_date_bcd,
    input  logic        rtc_valid,
    input  logic        wr_ack,
    output logic [23:0] time_bcd,
    output logic [23:0] date_bcd,
    output logic [23:0] timer_bcd,
    output logic        AM_PM,
    output logic        formato_hora,
    output logic [2:0]  config_mode,
    output logic [1:0]  cursor_location,
    output logic        wr_req,
    output logic [23:0] wr_time_bcd,
    output logic [23:0] wr_date_bcd
);

    state_e             state_q, state_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [23:0]        time_q, time_d, date_q, date_d, timer_q, timer_d;
    logic               fmt_q, fmt_d, am_pm_q, am_pm_d, wr_req_q, wr_req_d;
    logic [23:0]        wr_time_q, wr_date_q;

    logic [23:0]        sel_word, adj_word;
    logic [7:0]         sel_pair, adj_pair;
    logic [15:0]        lim;

    function automatic logic [7:0] to_12h(input logic [7:0] hh);
        logic [7:0] r;
        r = hh;
        if (hh == 8'h00) begin
            r = 8'h12;
        end else if (hh == 8'h20 || hh == 8'h21) begin
            r = hh - 8'h18;
        end else if (hh >= 8'h13) begin
            r = hh - 8'h12;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        wr_req_d = 1'b0;
        case (state_q)
            NORMAL:   if (btn_mode) state_d = CFG_TIME;
            CFG_TIME: if (btn_mode) state_d = CFG_DATE;
`ifdef TIMER_CFG_EN
            CFG_DATE:  if (btn_mode) state_d = CFG_TIMER;
            CFG_TIMER: if (btn_mode) state_d = WRITE;
`else
            CFG_DATE:  if (btn_mode) state_d = WRITE;
`endif
            WRITE: begin
                // First WRITE cycle raises the request; ack only counts once it is up.
                if (wr_req_q && wr_ack) begin
                    state_d = NORMAL;
                end else begin
                    wr_req_d = 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_comb begin
        sel_word = time_q;
        case (state_q)
            CFG_DATE:  sel_word = date_q;
            CFG_TIMER: sel_word = timer_q;
            default:   ;
        endcase
        case (cursor_q)
            2'd0:    sel_pair = sel_word[23:16];
            2'd1:    sel_pair = sel_word[15:8];
            default: sel_pair = sel_word[7:0];
        endcase
        lim = field_limits(state_q, cursor_q);
    end

    bcd_pair_adj u_adj (
        .val     (sel_pair),
        .min_val (lim[15:8]),
        .max_val (lim[7:0]),
        .inc     (btn_up & ~btn_mode),
        .dec     (btn_down & ~btn_mode),
        .result  (adj_pair)
    );

    always_comb begin
        adj_word = sel_word;
        case (cursor_q)
            2'd0:    adj_word[23:16] = adj_pair;
            2'd1:    adj_word[15:8]  = adj_pair;
            default: adj_word[7:0]   = adj_pair;
        endcase

        time_d  = time_q;
        date_d  = date_q;
        timer_d = timer_q;
        case (state_q)
            NORMAL: begin
                if (rtc_valid) begin
                    time_d = rtc_time_bcd;
                    date_d = rtc_date_bcd;
                end
            end
            CFG_TIME: time_d = adj_word;
            CFG_DATE: date_d = adj_word;
`ifdef TIMER_CFG_EN
            CFG_TIMER: timer_d = adj_word;
`endif
            default: ;
        endcase

        cursor_d = cursor_q;
        if (state_d != state_q) begin
            cursor_d = '0;
        end else if (!btn_mode && (btn_right ^ btn_left)) begin
            if (btn_right) begin
                cursor_d = (cursor_q == CUR_W'(2)) ? '0 : cursor_q + 1'b1;
            end else begin
                cursor_d = (cursor_q == '0) ? CUR_W'(2) : cursor_q - 1'b1;
            end
        end

        fmt_d   = fmt_q ^ fmt_toggle;
        am_pm_d = (time_d[23:16] >= 8'h12);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= NORMAL;
            cursor_q <= '0;
            time_q   <= TIME_RST;
            date_q   <= DATE_RST;
            timer_q  <= TIMER_RST;
            fmt_q    <= 1'b0;
            am_pm_q  <= 1'b0;
            wr_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            time_q   <= time_d;
            date_q   <= date_d;
            timer_q  <= timer_d;
            fmt_q    <= fmt_d;
            am_pm_q  <= am_pm_d;
            wr_req_q <= wr_req_d;
        end
    end

    // Time/date cannot change in WRITE, so tracking them keeps the payload stable.
    always_ff @(posedge clock) begin
        wr_time_q <= time_q;
        wr_date_q <= date_q;
    end

    assign time_bcd        = {fmt_q ? to_12h(time_q[23:16]) : time_q[23:16], time_q[15:0]};
    assign date_bcd        = date_q;
    assign timer_bcd       = timer_q;
    assign AM_PM           = am_pm_q;
    assign formato_hora    = fmt_q;
    assign config_mode     = state_q;
    assign cursor_location = cursor_q;
    assign wr_req          = wr_req_q;
    assign wr_time_bcd     = wr_time_q;
    assign wr_date_bcd     = wr_date_q;

endmodule

// File: tb/tb_time_config_ctrl.sv
// Bench for time_config_ctrl: directed scenarios plus random pulses, checked
// against an integer-valued reference model of the controller.
module tb_time_config_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 0, btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, fmt_toggle = 0;
    logic [23:0] rtc_time_bcd = '0, rtc_date_bcd = '0;
    logic        rtc_valid = 0, wr_ack = 0;
    logic [23:0] time_bcd, date_bcd, timer_bcd, wr_time_bcd, wr_date_bcd;
    logic        AM_PM, formato_hora, wr_req;
    logic [2:0]  config_mode;
    logic [1:0]  cursor_location;

    time_config_ctrl dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .fmt_toggle(fmt_toggle),
        .rtc_time_bcd(rtc_time_bcd), .rtc_date_bcd(rtc_date_bcd),
        .rtc_valid(rtc_valid), .wr_ack(wr_ack),
        .time_bcd(time_bcd), .date_bcd(date_bcd), .timer_bcd(timer_bcd),
        .AM_PM(AM_PM), .formato_hora(formato_hora), .config_mode(config_mode),
        .cursor_location(cursor_location), .wr_req(wr_req),
        .wr_time_bcd(wr_time_bcd), .wr_date_bcd(wr_date_bcd)
    );

    always #5 clock = ~clock;

`ifdef TIMER_CFG_EN
    localparam bit HAS_TIMER = 1'b1;
`else
    localparam bit HAS_TIMER = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Model: mode 0..4 = NORMAL, CFG_TIME, CFG_DATE, CFG_TIMER, WRITE; fields as integers.
    int m_mode, m_cur, m_h, m_mi, m_s, m_d, m_mo, m_y, m_th, m_tm, m_ts;
    bit m_fmt, m_wreq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int wrap(input int v, input int lo, input int hi, input int dir);
        int n;
        n = hi - lo + 1;
        return lo + ((v - lo + dir + n) % n);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_fmt = 0; m_wreq = 0;
        m_h = 0; m_mi = 0; m_s = 0;
        m_d = 1; m_mo = 1; m_y = 0;
        m_th = 0; m_tm = 0; m_ts = 0;
    endtask

    task automatic model_step();
        int nmode, dir;
        nmode = m_mode;
        if (m_mode == 4) begin
            if (m_wreq && wr_ack) nmode = 0;
        end else if (btn_mode) begin
            nmode = (m_mode == 2 && !HAS_TIMER) ? 4 : m_mode + 1;
        end
        if (m_mode == 0 && rtc_valid) begin
            m_h = from_bcd(rtc_time_bcd[23:16]); m_mi = from_bcd(rtc_time_bcd[15:8]); m_s = from_bcd(rtc_time_bcd[7:0]);
            m_d = from_bcd(rtc_date_bcd[23:16]); m_mo = from_bcd(rtc_date_bcd[15:8]); m_y = from_bcd(rtc_date_bcd[7:0]);
        end
        if (m_mode >= 1 && m_mode <= 3 && !btn_mode && (btn_up != btn_down)) begin
            dir = btn_up ? 1 : -1;
            case (m_mode)
                1: case (m_cur)
                       0: m_h = wrap(m_h, 0, 23, dir);
                       1: m_mi = wrap(m_mi, 0, 59, dir);
                       default: m_s = wrap(m_s, 0, 59, dir);
                   endcase
                2: case (m_cur)
                       0: m_d = wrap(m_d, 1, 31, dir);
                       1: m_mo = wrap(m_mo, 1, 12, dir);
                       default: m_y = wrap(m_y, 0, 99, dir);
                   endcase
                default: case (m_cur)
                       0: m_th = wrap(m_th, 0, 23, dir);
                       1: m_tm = wrap(m_tm, 0, 59, dir);
                       default: m_ts = wrap(m_ts, 0, 59, dir);
                   endcase
            endcase
        end
        m_wreq = (m_mode == 4) && !(m_wreq && wr_ack);
        if (nmode != m_mode) m_cur = 0;
        else if (!btn_mode && (btn_right != btn_left)) m_cur = btn_right ? (m_cur + 1) % 3 : (m_cur + 2) % 3;
        m_fmt = m_fmt ^ fmt_toggle;
        m_mode = nmode;
    endtask

    task automatic compare_all();
        int hh;
        hh = m_fmt ? ((m_h % 12 == 0) ? 12 : m_h % 12) : m_h;
        check("config_mode", 32'(config_mode), 32'(m_mode));
        check("cursor", 32'(cursor_location), 32'(m_cur));
        check("time_bcd", 32'(time_bcd), 32'({bcd(hh), bcd(m_mi), bcd(m_s)}));
        check("date_bcd", 32'(date_bcd), 32'({bcd(m_d), bcd(m_mo), bcd(m_y)}));
        check("timer_bcd", 32'(timer_bcd), 32'({bcd(m_th), bcd(m_tm), bcd(m_ts)}));
        check("am_pm", 32'(AM_PM), 32'(m_h >= 12));
        check("formato", 32'(formato_hora), 32'(m_fmt));
        check("wr_req", 32'(wr_req), 32'(m_wreq));
        if (m_wreq) begin
            check("wr_time", 32'(wr_time_bcd), 32'({bcd(m_h), bcd(m_mi), bcd(m_s)}));
            check("wr_date", 32'(wr_date_bcd), 32'({bcd(m_d), bcd(m_mo), bcd(m_y)}));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        fmt_toggle = 0; rtc_valid = 0;
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("reset_wr_req_async", 32'(wr_req), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        compare_all();
    endtask

    task automatic rand_rtc();
        rtc_time_bcd = {bcd($urandom_range(23)), bcd($urandom_range(59)), bcd($urandom_range(59))};
        rtc_date_bcd = {bcd($urandom_range(31, 1)), bcd($urandom_range(12, 1)), bcd($urandom_range(99))};
    endtask

    logic [23:0] pay_t, pay_d;

    initial begin
        model_reset();
        #12;
        compare_all();
        check("reset_date", 32'(date_bcd), 32'h010100);
        reset = 1'b0;

        // RTC mirror in NORMAL
        rtc_time_bcd = 24'h235959; rtc_date_bcd = 24'h011299; rtc_valid = 1; tick();
        check("s1_time", 32'(time_bcd), 32'h235959);
        check("s1_ampm", 32'(AM_PM), 32'd1);

        // Hour wrap in CFG_TIME
        btn_mode = 1; tick();
        btn_up = 1; tick();
        check("s2_hh_up", 32'(time_bcd[23:16]), 32'h00);
        btn_down = 1; tick();
        check("s2_hh_dn", 32'(time_bcd[23:16]), 32'h23);

        // Month and day wrap in CFG_DATE
        btn_mode = 1; tick();
        btn_right = 1; tick();
        btn_up = 1; tick();
        check("s3_month", 32'(date_bcd[15:8]), 32'h01);
        btn_left = 1; tick();
        btn_down = 1; tick();
        check("s3_day", 32'(date_bcd[23:16]), 32'h31);

        // Write handshake with a slow ack
        btn_mode = 1; tick();
        if (HAS_TIMER) begin btn_mode = 1; tick(); end
        tick();
        pay_t = wr_time_bcd; pay_d = wr_date_bcd;
        check("s5_wr_time", 32'(wr_time_bcd), 32'h235959);
        check("s5_wr_date", 32'(wr_date_bcd), 32'h310199);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s5_hold_req", 32'(wr_req), 32'd1);
            check("s5_stable", 32'({wr_time_bcd, wr_date_bcd} == {pay_t, pay_d}), 32'd1);
        end
        wr_ack = 1; tick(); wr_ack = 0;
        check("s5_mode", 32'(config_mode), 32'd0);
        check("s5_req_low", 32'(wr_req), 32'd0);

        // 12 h display mapping
        fmt_toggle = 1; tick();
        rtc_time_bcd = 24'h000000; rtc_valid = 1; tick();
        check("s4_hh00", 32'(time_bcd[23:16]), 32'h12);
        check("s4_am", 32'(AM_PM), 32'd0);
        rtc_time_bcd = 24'h130000; rtc_valid = 1; tick();
        check("s4_hh13", 32'(time_bcd[23:16]), 32'h01);
        check("s4_pm", 32'(AM_PM), 32'd1);
        fmt_toggle = 1; tick();

        // btn_mode wins over adjust, then reset during WRITE
        btn_mode = 1; tick();
        btn_right = 1; tick();
        btn_mode = 1; btn_up = 1; btn_left = 1; tick();
        check("s6_mode", 32'(config_mode), 32'd2);
        check("s6_time", 32'(time_bcd), 32'h130000);
        check("s6_cursor", 32'(cursor_location), 32'd0);
        btn_mode = 1; tick();
        if (HAS_TIMER) begin btn_mode = 1; tick(); end
        tick();
        check("s6_req_up", 32'(wr_req), 32'd1);
        async_reset_pulse();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            btn_mode   = ($urandom_range(7) == 0);
            btn_up     = ($urandom_range(2) == 0);
            btn_down   = ($urandom_range(2) == 0);
            btn_left   = ($urandom_range(4) == 0);
            btn_right  = ($urandom_range(4) == 0);
            fmt_toggle = ($urandom_range(15) == 0);
            rtc_valid  = $urandom_range(1);
            wr_ack     = ($urandom_range(2) == 0);
            rand_rtc();
            tick();
            if (i % 700 == 350 && wr_req) async_reset_pulse();
        end
        wr_ack = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
